// File: rtl/ps2_evt_pkg.sv
// Shared types for the ps2_key event path: the queued event record and
// the helper that forms the 11-bit ps2_key word from it.
package ps2_evt_pkg;
  localparam int PS2_W = 11;

  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_evt_t;

  function automatic logic [PS2_W-1:0] ps2_pack(input logic toggle, input ps2_evt_t evt);
    return {toggle, evt};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is accepted when a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ps2_key_event_gen.sv
// Converts NKEYS virtual key levels into rate-limited make/break events on
// the 11-bit ps2_key bus: scanner -> event FIFO -> emitter.
module ps2_key_event_gen
  import ps2_evt_pkg::*;
#(
  parameter int NKEYS      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP        = 4
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [NKEYS-1:0]              key_in,
  input  logic [NKEYS*9-1:0]            key_code,
  input  logic                          mask,
  output logic [PS2_W-1:0]              ps2_key,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int IW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int GW = $clog2(GAP + 1);
  localparam int EW = $bits(ps2_evt_t);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  logic [NKEYS-1:0] tgt, reported, diff;
  logic             scan_hit;
  logic [IW-1:0]    scan_idx;
  logic [EW-1:0]    push_evt, fifo_dout;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic             state;
  logic [GW-1:0]    gap;

  assign tgt  = mask ? '0 : key_in;
  assign diff = tgt ^ reported;

  // Downward loop so the lowest differing index wins.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = NKEYS-1; i >= 0; i--) begin
      if (diff[i]) begin
        scan_hit = 1'b1;
        scan_idx = IW'(i);
      end
    end
  end

  assign push_evt  = {tgt[scan_idx], key_code[9*scan_idx +: 9]};
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign fifo_push = scan_hit && (!fifo_full || fifo_pop);

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (fifo_push),
    .din     (push_evt),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // WAIT leaves one cycle early (at gap==1) so pops land exactly GAP apart.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_IDLE;
      gap      <= '0;
      ps2_key  <= '0;
      reported <= '0;
    end else begin
      if (fifo_push) reported[scan_idx] <= tgt[scan_idx];
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            ps2_key <= ps2_pack(~ps2_key[PS2_W-1], ps2_evt_t'(fifo_dout));
            gap     <= GW'(GAP - 1);
            state   <= (GAP > 1) ? ST_WAIT : ST_IDLE;
          end
        end
        default: begin
          gap <= gap - 1'b1;
          if (gap == GW'(1)) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (fifo_level != '0) || (state == ST_WAIT);
endmodule

// File: tb/tb_ps2_key_event_gen.sv
// Randomized and directed stimulus against a queue-based event model.
module tb_ps2_key_event_gen;
  localparam int NK = 16;
  localparam int FD = 8;
  localparam int GP = 4;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [NK-1:0]     key_in;
  logic [NK*9-1:0]   key_code;
  logic              mask;
  logic [10:0]       ps2_key;
  logic              busy;
  logic [3:0]        fifo_level;

  ps2_key_event_gen #(.NKEYS(NK), .FIFO_DEPTH(FD), .GAP(GP)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .key_in     (key_in),
    .key_code   (key_code),
    .mask       (mask),
    .ps2_key    (ps2_key),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;

  logic [NK-1:0] m_rep;
  logic [9:0]    m_q[$];
  int            m_cool;
  logic [10:0]   m_ps2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each cycle at most one pop (when the cooldown has elapsed) and
  // one push of the lowest-index key whose wanted state differs from reported.
  task automatic model_cycle();
    logic [NK-1:0] want;
    logic [9:0]    e;
    bit            pop_ok, found;
    int            k;
    if (reset) begin
      m_rep = '0; m_q.delete(); m_cool = 0; m_ps2 = '0;
      return;
    end
    want   = mask ? '0 : key_in;
    pop_ok = (m_cool == 0) && (m_q.size() > 0);
    found  = 0; k = 0;
    for (int i = 0; i < NK; i++)
      if (!found && want[i] != m_rep[i]) begin found = 1; k = i; end
    if (pop_ok) begin
      e = m_q.pop_front();
      m_ps2 = {~m_ps2[10], e};
      m_cool = GP - 1;
    end else if (m_cool > 0) m_cool--;
    if (found && (m_q.size() < FD || pop_ok)) begin
      m_q.push_back({want[k], key_code[9*k +: 9]});
      m_rep[k] = want[k];
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk_sys); #1;
    chk("ps2_key", 32'(ps2_key), 32'(m_ps2));
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    chk("busy", 32'(busy), 32'((m_q.size() != 0) || (m_cool != 0)));
    chk("level_bound", 32'(fifo_level <= FD), 32'd1);
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; key_in = '0; mask = 1'b0;
    for (int i = 0; i < NK; i++) key_code[9*i +: 9] = 9'(8'h30 + i);
    key_code[0 +: 9]  = 9'h075;
    key_code[9 +: 9]  = 9'h016;
    key_code[18 +: 9] = 9'h01E;
    key_code[27 +: 9] = 9'h026;
    key_code[36 +: 9] = 9'h174;
    @(negedge clk_sys);
    step(); step();
    reset = 1'b0;
    chk("reset_ps2", 32'(ps2_key), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // key0 press then release
    for (int c = 0; c < 7; c++) step();
    key_in[0] = 1'b1; step(); step();
    chk("k0_make", 32'(ps2_key), 32'h675);
    for (int c = 0; c < 6; c++) step();
    key_in[0] = 1'b0; step(); step();
    chk("k0_break", 32'(ps2_key), 32'h075);
    for (int c = 0; c < 6; c++) step();

    // keys 1..3 together, GAP-spaced output
    do_reset();
    key_in[3:1] = 3'b111; step(); step();
    chk("k1_make", 32'(ps2_key), 32'h616);
    step(); step(); step();
    chk("k1_hold", 32'(ps2_key), 32'h616);
    step();
    chk("k2_make", 32'(ps2_key), 32'h21E);
    step(); step(); step(); step();
    chk("k3_make", 32'(ps2_key), 32'h626);
    for (int c = 0; c < 8; c++) step();

    // extended key
    key_in = '0; do_reset();
    key_in[4] = 1'b1; step(); step();
    chk("k4_ext", 32'(ps2_key), 32'h774);
    for (int c = 0; c < 6; c++) step();

    // all keys, backlog drains in order
    key_in = '0; do_reset();
    key_in = '1;
    for (int c = 0; c < 16*GP + 8; c++) step();
    chk("all_idle", 32'(busy), 32'h0);

    // mask forces breaks then makes for held keys
    key_in = '0; do_reset();
    key_in[0] = 1'b1; key_in[5] = 1'b1;
    for (int c = 0; c < 12; c++) step();
    mask = 1'b1;
    for (int c = 0; c < 12; c++) step();
    mask = 1'b0;
    for (int c = 0; c < 12; c++) step();

    // reset with a backlog queued
    key_in = '1;
    for (int c = 0; c < 6; c++) step();
    do_reset();
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    key_in = '0; key_in[2] = 1'b1;
    step(); step();
    chk("k2_remake", 32'(ps2_key), 32'h61E);
    for (int c = 0; c < 6; c++) step();

    // random soak
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) key_in[$urandom_range(NK-1)] ^= 1'b1;
      if ($urandom_range(199) == 0) key_in = NK'($urandom);
      if ($urandom_range(63) == 0) mask = ~mask;
      reset = ($urandom_range(399) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
